// File: rtl/sha256d_multi.sv
// Variable-length SHA-256 / SHA-256d controller with internal FIPS 180-4 padding,
// built around the single-round-per-cycle sha256_stream core defined first.
module sha256_stream (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] state_in,
    output logic         rq,
    output logic [3:0]   word,
    input  logic         rdy,
    input  logic [31:0]  data,
    output logic         done,
    output logic [255:0] state_out
);
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  w [0:15];
    logic [255:0] hin;
    logic [6:0]   t;
    logic         run;
    logic [31:0]  wt, t1, t2, s0, s1;
    logic         step;

    assign word = t[3:0];

    // w[] is a sliding window: w[15] is W[t-1] and w[0] is W[t-16].
    always_comb begin
        s0   = {w[1][6:0], w[1][31:7]} ^ {w[1][17:0], w[1][31:18]} ^ (w[1] >> 3);
        s1   = {w[14][16:0], w[14][31:17]} ^ {w[14][18:0], w[14][31:19]} ^ (w[14] >> 10);
        wt   = (t < 7'd16) ? data : s1 + w[9] + s0 + w[0];
        t1   = h + ({e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]})
                 + ((e & f) ^ (~e & g)) + K[t[5:0]] + wt;
        t2   = ({a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]})
                 + ((a & b) ^ (a & c) ^ (b & c));
        step = run && ((t < 7'd16) ? (rq && rdy) : (t < 7'd64));
    end

    always_ff @(posedge clk) begin
        if (start) begin
            {a, b, c, d, e, f, g, h} <= state_in;
            hin <= state_in;
        end else if (step) begin
            {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
            for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
            w[15] <= wt;
        end
    end

    // Each message word is requested separately; rq drops for a cycle after every capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run       <= 1'b0;
            rq        <= 1'b0;
            done      <= 1'b0;
            t         <= '0;
            state_out <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                t   <= '0;
                run <= 1'b1;
                rq  <= 1'b1;
            end else if (step) begin
                t  <= t + 7'd1;
                rq <= 1'b0;
            end else if (run && t == 7'd64) begin
                run       <= 1'b0;
                done      <= 1'b1;
                state_out <= {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
            end else if (run && t < 7'd16 && !rq) begin
                rq <= 1'b1;
            end
        end
    end
endmodule

module sha256d_multi #(
    parameter int MAX_BLOCKS = 4,
    parameter int BLK_W      = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1,
    parameter int LEN_W      = $clog2(MAX_BLOCKS * 64)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             rdy,
    input  logic [31:0]      data,
    output logic [BLK_W+3:0] addr,
    output logic             rq,
    output logic [255:0]     hash,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HASH   = 2'd1;
    localparam logic [1:0] S_DOUBLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam int L_MAX = MAX_BLOCKS * 64 - 9;

    logic [1:0]       state;
    logic [LEN_W-1:0] len;
    logic             dbl;
    logic [BLK_W:0]   nb;
    logic [BLK_W-1:0] blk;
    logic [255:0]     first, chain, core_out;
    logic             core_start, core_rq, core_rdy, core_done;
    logic [3:0]       core_word;
    logic [31:0]      core_data, int_word, bus_word;
    logic             from_bus;
    int               bofs, k;

    sha256_stream core (
        .clk(clk), .rst_n(rst_n), .start(core_start), .state_in(chain),
        .rq(core_rq), .word(core_word), .rdy(core_rdy), .data(core_data),
        .done(core_done), .state_out(core_out)
    );

    // Decide where the requested word comes from and build its padded value.
    always_comb begin
        bofs     = (int'(blk) * 16 + int'(core_word)) * 4;
        k        = int'(len) - bofs;
        from_bus = 1'b0;
        int_word = '0;
        if (state == S_DOUBLE) begin
            if (core_word < 4'd8)        int_word = first[{3'd7 - core_word[2:0], 5'd0} +: 32];
            else if (core_word == 4'd8)  int_word = 32'h80000000;
            else if (core_word == 4'd15) int_word = 32'h00000100;
        end else if (bofs < int'(len)) begin
            from_bus = 1'b1;
        end else if (bofs == int'(len)) begin
            int_word = 32'h80000000;
        end else if ({1'b0, blk} == nb - 1'b1 && core_word == 4'd15) begin
            int_word = 32'(len) << 3;
        end
        case (k)
            1:       bus_word = {data[31:24], 24'h800000};
            2:       bus_word = {data[31:16], 16'h8000};
            3:       bus_word = {data[31:8], 8'h80};
            default: bus_word = data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rq         <= 1'b0;
            addr       <= '0;
            hash       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_start <= 1'b0;
            core_rdy   <= 1'b0;
            core_data  <= '0;
            blk        <= '0;
            nb         <= '0;
            len        <= '0;
            dbl        <= 1'b0;
            chain      <= IV;
            first      <= '0;
        end else begin
            core_start <= 1'b0;
            core_rdy   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (int'(msg_len) > L_MAX) begin
                            err <= 1'b1;
                        end else begin
                            len        <= msg_len;
                            dbl        <= mode;
                            nb         <= (BLK_W + 1)'((int'(msg_len) + 72) / 64);
                            blk        <= '0;
                            chain      <= IV;
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_HASH;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    if (core_done) begin
                        if (state == S_HASH && {1'b0, blk} < nb - 1'b1) begin
                            blk        <= blk + 1'b1;
                            chain      <= core_out;
                            core_start <= 1'b1;
                        end else if (state == S_HASH && dbl) begin
                            first      <= core_out;
                            chain      <= IV;
                            core_start <= 1'b1;
                            state      <= S_DOUBLE;
                        end else begin
                            hash  <= core_out;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (rq) begin
                        if (rdy) begin
                            rq        <= 1'b0;
                            core_rdy  <= 1'b1;
                            core_data <= bus_word;
                        end
                    end else if (core_rq && !core_rdy) begin
                        if (from_bus) begin
                            rq   <= 1'b1;
                            addr <= {blk, core_word};
                        end else begin
                            core_rdy  <= 1'b1;
                            core_data <= int_word;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sha256d_multi.sv
// Randomised self-checking bench for sha256d_multi against a byte-level SHA-256 model
// plus known-answer vectors.
module tb_sha256d_multi;
    localparam int MAX_BLOCKS = 4;
    localparam int BLK_W = 2;
    localparam int LEN_W = 8;
    localparam logic [639:0] GENESIS = 640'h0100000000000000000000000000000000000000000000000000000000000000000000003ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a29ab5f49ffff001d1dac2b7c;
    localparam logic [255:0] GENESIS_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic             rdy = 1'b0;
    logic [LEN_W-1:0] msg_len = '0;
    logic [31:0]      data = '0;
    logic [BLK_W+3:0] addr;
    logic             rq, busy, done, err;
    logic [255:0]     hash;

    logic [7:0] mem [0:255];
    int         max_delay = 0;
    int         addr_log [$];
    int         pass_cnt = 0;
    int         check_cnt = 0;

    always #5 clk = ~clk;

    sha256d_multi #(.MAX_BLOCKS(MAX_BLOCKS), .BLK_W(BLK_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .msg_len(msg_len),
        .rdy(rdy), .data(data), .addr(addr), .rq(rq), .hash(hash),
        .busy(busy), .done(done), .err(err)
    );

    task automatic check_output(input string tag, input logic [255:0] got, input logic [255:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256_ref(input logic [7:0] msg [0:255], input int len);
        logic [7:0]  p [0:319];
        logic [31:0] hv [0:7];
        logic [31:0] v [0:7];
        logic [31:0] w [0:63];
        logic [31:0] t1, t2;
        longint      bits;
        int          nb;
        hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        nb = (len + 8) / 64 + 1;
        bits = longint'(len) * 8;
        for (int i = 0; i < 320; i++) p[i] = (i < len) ? msg[i] : ((i == len) ? 8'h80 : 8'h00);
        for (int i = 0; i < 8; i++) p[nb * 64 - 1 - i] = 8'(bits >> (8 * i));
        for (int blk = 0; blk < nb; blk++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) w[t] = {p[blk*64+4*t], p[blk*64+4*t+1], p[blk*64+4*t+2], p[blk*64+4*t+3]};
                else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                          + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            end
            v = hv;
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
                t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
                v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) hv[i] = hv[i] + v[i];
        end
        return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    endfunction

    function automatic logic [255:0] model_digest(input int len, input logic dbl);
        logic [7:0]   tmp [0:255];
        logic [255:0] d;
        d = sha256_ref(mem, len);
        if (dbl) begin
            for (int i = 0; i < 256; i++) tmp[i] = (i < 32) ? d[255 - 8*i -: 8] : 8'h00;
            d = sha256_ref(tmp, 32);
        end
        return d;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic load_bytes(input logic [639:0] v, input int n);
        for (int i = 0; i < n; i++) mem[i] = v[8*(n-1-i) +: 8];
    endtask

    // Bus slave: answers each request after a random number of wait cycles.
    initial begin : bus_model
        int   wait_cnt;
        int   a;
        logic pending;
        wait_cnt = 0;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            rdy = 1'b0;
            if (!rq) pending = 1'b0;
            else if (!pending) begin
                pending = 1'b1;
                wait_cnt = int'($urandom_range(max_delay, 0));
            end
            if (pending) begin
                if (wait_cnt == 0) begin
                    a = int'(addr);
                    rdy = 1'b1;
                    data = {mem[4*a], mem[4*a+1], mem[4*a+2], mem[4*a+3]};
                    addr_log.push_back(a);
                    pending = 1'b0;
                end else wait_cnt--;
            end
        end
    end

    task automatic apply_stimulus(input int len, input logic md, input int delay,
                                  input int ignore_at, output logic [255:0] got);
        int           cycles;
        int           mism;
        logic         err_seen;
        logic [255:0] exp;
        exp = model_digest(len, md);
        addr_log.delete();
        max_delay = delay;
        @(negedge clk);
        start = 1'b1; mode = md; msg_len = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", busy, 1);
        cycles = 0;
        err_seen = 1'b0;
        while (cycles < 5000) begin
            @(negedge clk);
            cycles++;
            if (done) break;
            if (err) err_seen = 1'b1;
            start = (cycles == ignore_at);
            if (start) begin
                mode = ~md;
                msg_len = LEN_W'(MAX_BLOCKS * 64 - 8);
            end
        end
        start = 1'b0;
        check_output("done_in_budget", done, 1);
        check_output("hash_vs_model", hash, exp);
        check_output("busy_with_done", busy, 1);
        if (ignore_at > 0) check_output("no_err_while_busy", err_seen, 0);
        got = hash;
        @(negedge clk);
        check_output("done_one_cycle", done, 0);
        check_output("busy_after_done", busy, 0);
        check_output("hash_held", hash, exp);
        check_output("rq_count", addr_log.size(), (len + 3) / 4);
        mism = 0;
        foreach (addr_log[i]) if (addr_log[i] != i) mism++;
        check_output("rq_addrs", mism, 0);
    endtask

    initial begin
        logic [255:0] h;
        int           cycles;
        logic         done_seen;
        int           lens [6] = '{55, 56, 63, 64, 119, 247};
        int           len;

        repeat (3) @(negedge clk);
        check_output("reset_ctrl", {rq, done, err, busy}, 0);
        check_output("reset_addr", addr, 0);
        check_output("reset_hash", hash, 0);
        rst_n = 1'b1;

        fill_random();
        apply_stimulus(0, 1'b0, 0, 0, h);
        check_output("kat_empty", h, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        fill_random();
        load_bytes(640'h61626364, 4);
        apply_stimulus(3, 1'b0, 2, 0, h);
        check_output("kat_abc", h, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        fill_random();
        load_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 56);
        apply_stimulus(56, 1'b0, 1, 0, h);
        check_output("kat_448", h, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

        fill_random();
        load_bytes(GENESIS, 80);
        apply_stimulus(80, 1'b1, 5, 0, h);
        check_output("kat_genesis", h, GENESIS_HASH);

        // Over-long request must be refused with a single err pulse.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; msg_len = LEN_W'(MAX_BLOCKS * 64 - 8);
        @(negedge clk);
        start = 1'b0;
        check_output("err_pulse", err, 1);
        check_output("err_no_busy", {busy, rq}, 0);
        @(negedge clk);
        check_output("err_one_cycle", err, 0);
        check_output("err_still_idle", busy, 0);

        apply_stimulus(80, 1'b1, 3, 30, h);
        check_output("kat_genesis_ignored_start", h, GENESIS_HASH);

        // Abort during block 1 of the header run.
        max_delay = 1;
        addr_log.delete();
        @(negedge clk);
        start = 1'b1; mode = 1'b1; msg_len = LEN_W'(80);
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!(rq && addr >= 16) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        check_output("reached_block1", rq && addr >= 16, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_output("midreset_ctrl", {rq, done, err, busy}, 0);
        check_output("midreset_addr", addr, 0);
        check_output("midreset_hash", hash, 0);
        done_seen = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check_output("no_done_after_reset", done_seen, 0);
        apply_stimulus(80, 1'b1, 4, 0, h);
        check_output("kat_genesis_restart", h, GENESIS_HASH);

        for (int i = 0; i < 10; i++) begin
            fill_random();
            len = (i < 6) ? lens[i] : int'($urandom_range(247, 0));
            apply_stimulus(len, 1'($urandom), int'($urandom_range(3, 0)), 0, h);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/sha256d_multi.md
# sha256d_multi

Parametrised successor to the fixed 80-byte Bitcoin double-SHA-256 controller. It hashes a message of run-time byte length (up to `MAX_BLOCKS` 64-byte blocks) in single (SHA-256) or double (SHA-256d) mode. It generates all FIPS 180-4 padding internally and fetches only message-bearing words from the bus. It wraps one `sha256_stream` core and sits between the work/header buffer and the miner/result logic.

## Interface

**Parameters**
- `MAX_BLOCKS`, default 4: maximum padded message blocks; must be ≥ 1.
- `BLK_W`, default `max(1, clog2(MAX_BLOCKS))`: block-index width.
- `LEN_W`, default `clog2(MAX_BLOCKS*64)`: byte-length width.

**Ports** (one clock; reset is synchronous and active-low)
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous active-low reset; also drives the core's `rst_n`.
- `start`  in  1  request; sampled only in S_IDLE.
- `mode`  in  1  0 = SHA-256, 1 = SHA-256d; sampled with `start`.
- `msg_len`  in  LEN_W  message length in bytes; sampled with `start`.
- `rdy`  in  1  bus data valid for the current `addr`.
- `data`  in  32  bus word, big-endian (byte 0 = bits 31:24).
- `addr`  out  BLK_W+4  `{block, word}` index of the requested word.
- `rq`  out  1  bus request.
- `hash`  out  256  final digest; valid while `done` is high and held until the next accepted `start`.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse on a rejected `start`.

## Operation

- **Start handling.** On `start` in S_IDLE, compute L_MAX = MAX_BLOCKS*64−9.
  - If `msg_len` > L_MAX: pulse `err`; stay in S_IDLE.
  - Otherwise: latch L = `msg_len` and `mode`; NB = floor((L+72)/64); blk = 0; go to S_HASH.
- **States.**
  - S_IDLE.
  - S_HASH: runs NB passes.
  - S_DOUBLE: runs one pass, only when `mode` = 1.
  - S_DONE: lasts one cycle, then returns to S_IDLE.
- **Core chaining (`state_in`).**
  - Block 0 of S_HASH and the S_DOUBLE pass use the standard IV (6a09e667 … 5be0cd19).
  - Later blocks use the previous `state_out`.
  - The core's `start` is pulsed once per pass.
- **Word source in S_HASH.** For core request word w, global index g = blk*16+w, byte offset b = 4g:
  - b+4 ≤ L: word comes from the bus.
  - b < L < b+4: word comes from the bus. Keep the top L−b bytes; byte L−b becomes 0x80; lower bytes become 0.
  - b = L: 0x80000000.
  - blk = NB−1 and w = 15: L*8 (zero-extended).
  - Anything else, including word 14 of the last block: 0.
- **Word source in S_DOUBLE.** Words 0–7 = first digest (word 0 = bits 255:224); word 8 = 0x80000000; word 15 = 0x00000100; all others 0.
- **Bus handshake.** `rq` is raised only for bus-sourced words.
  - `addr` = {blk, w} is stable while `rq` is high.
  - Data is captured in the cycle `rdy` = 1.
  - `rq` drops the next cycle.
  - Internally sourced words are answered with core `rdy` one cycle after core `rq`, with no bus traffic.
- **Pass completion.** On core `done`:
  - If blk < NB−1: increment blk and start the next pass.
  - Else if `mode` = 1: latch the digest and enter S_DOUBLE.
  - Else: enter S_DONE.
- **Output.** `hash` holds the final `state_out`.
- **Start while busy.** `start` outside S_IDLE is ignored; no `err` is raised.

## Timing

- **Reset.** `rq`, `done`, `err`, `busy`, `addr` = 0; `hash` = 0; state = S_IDLE. Reset applied mid-operation aborts on the next edge and issues no `done`.
- **Start.** An accepted `start` at edge N gives `busy` = 1 and core `start` = 1 at N+1.
- **Rejection.** `err` is high for the single cycle after the rejecting edge.
- **Completion.** `done` rises exactly 1 cycle after the final pass's core `done`. `busy` falls with `done`.
- **Stalls.** An unbounded `rdy` stall is legal; the core waits.
- **Back-to-back.** A `start` is accepted in the cycle after `done`.

## Test plan

- L=0, mode 0: no `rq` ever; `hash` = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; NB = 1.
- L=3, data 0x61626364 at addr 0, mode 0: exactly one `rq` (addr 0); core receives 0x61626380; `hash` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- L=56 ("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), mode 0: NB = 2; `rq` at addrs 0–13 only; `hash` = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Bitcoin genesis header, L=80, mode 1, random 0–5 cycle `rdy` delays: `rq` at addrs 0–15 and 16–19; `hash` = 6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000.
- `msg_len` = MAX_BLOCKS*64−8: `err` pulse and `busy` stays 0. Then `start` asserted during a valid run's S_HASH is ignored; that run completes correctly.
- `rst_n` low for 1 cycle during block 1 of the 80-byte run: next cycle all outputs 0 and no `done`; a restarted run gives the genesis hash.
